// File: rtl/mips32_pkg.sv
// Shared MIPS32 decoder definitions: opcodes, field positions, class/ALU enums.
// Used by the decoder RTL and its testbenches.
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_RR      = 3'd1,
        CLS_RM      = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } cls_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_MUL = 3'd5
    } alu_e;

    // stop: the word freezes the stream once it leaves the stage
    typedef struct packed {
        cls_e        cls;
        alu_e        alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        rs_use;
        logic        rt_use;
        logic        wr;
        logic        bz;
        logic        ill;
        logic        stop;
        logic [31:0] imm;
    } dec_t;

endpackage

// File: rtl/mips32_instr_decoder_if.sv
// Fetch-side and issue-side handshake bundle of the MIPS32 decoder.
// slave = decoder view, master = surrounding pipeline view.
interface mips32_instr_decoder_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [2:0]      out_cls;
    logic [2:0]      out_alu;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic            out_rs_use;
    logic            out_rt_use;
    logic [4:0]      out_dst;
    logic            out_wr;
    logic [31:0]     out_imm;
    logic            out_bz;

    modport slave (
        input  in_valid, instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_cls, out_alu,
        output out_rs, out_rt, out_rs_use, out_rt_use,
        output out_dst, out_wr, out_imm, out_bz
    );

    modport master (
        output in_valid, instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_cls, out_alu,
        input  out_rs, out_rt, out_rs_use, out_rt_use,
        input  out_dst, out_wr, out_imm, out_bz
    );
endinterface

// File: rtl/mips32_field_decode.sv
// Combinational MIPS32 field decoder: instr -> class, ALU op, reg use, dst, imm.
// DECODER_ILLEGAL_TRAP_EN: unknown opcodes decode as a stopping ILLEGAL class.
module mips32_field_decode
    import mips32_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);
    logic [5:0] op;

    always_comb begin
        op         = instr[OP_HI:OP_LO];
        dec        = '0;
        dec.cls    = CLS_NOP;
        dec.alu    = ALU_ADD;
        dec.rs     = instr[RS_HI:RS_LO];
        dec.rt     = instr[RT_HI:RT_LO];
        dec.imm    = {{16{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
        unique case (1'b1)
            (op[5:3] == 3'b000 && op[2:0] <= 3'd5): begin
                dec.cls    = CLS_RR;
                dec.alu    = alu_e'(op[2:0]);
                dec.rs_use = 1'b1;
                dec.rt_use = 1'b1;
                dec.dst    = instr[RD_HI:RD_LO];
            end
            (op == OP_ADDI || op == OP_SUBI || op == OP_SLTI): begin
                dec.cls    = CLS_RM;
                dec.alu    = (op == OP_SUBI) ? ALU_SUB :
                             (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
                dec.rs_use = 1'b1;
                dec.dst    = instr[RT_HI:RT_LO];
            end
            (op == OP_LW): begin
                dec.cls    = CLS_LOAD;
                dec.rs_use = 1'b1;
                dec.dst    = instr[RT_HI:RT_LO];
            end
            (op == OP_SW): begin
                dec.cls    = CLS_STORE;
                dec.rs_use = 1'b1;
                dec.rt_use = 1'b1;
            end
            (op == OP_BNEQZ || op == OP_BEQZ): begin
                dec.cls    = CLS_BRANCH;
                dec.rs_use = 1'b1;
                dec.bz     = (op == OP_BEQZ);
            end
            (op == OP_HLT): begin
                dec.cls    = CLS_HALT;
                dec.stop   = 1'b1;
            end
            default: begin
                dec.ill    = 1'b1;
`ifdef DECODER_ILLEGAL_TRAP_EN
                dec.cls    = CLS_ILLEGAL;
                dec.stop   = 1'b1;
`else
                dec.cls    = CLS_NOP;
`endif
            end
        endcase
        // r0 is hardwired, so writes to it are dropped at decode
        dec.wr = (dec.cls == CLS_RR || dec.cls == CLS_RM ||
                  dec.cls == CLS_LOAD) && (dec.dst != 5'd0);
    end
endmodule

// File: rtl/mips32_instr_decoder.sv
// Registered MIPS32 decode stage with load-use bubble, halt freeze and counters.
// DECODER_ILLEGAL_TRAP_EN: illegal opcodes halt the stream like HLT.
module mips32_instr_decoder
    import mips32_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PC_W  = 32
) (
    input  logic             clk1,
    input  logic             rst,
    mips32_instr_decoder_if.slave bus,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] dec_cnt
);
    dec_t            dec;
    dec_t            q;
    logic [PC_W-1:0] pc_q;
    logic            vld_q;
    logic            hlt_held;
    logic            hazard;
    logic            acc;
    logic            xfer;
    logic            bubble;

    mips32_field_decode u_fd (
        .instr (bus.instr),
        .dec   (dec)
    );

    // q.wr is already 0 for r0, so r0 never stalls
    assign hazard = vld_q && (q.cls == CLS_LOAD) && q.wr && bus.in_valid &&
                    ((dec.rs_use && dec.rs == q.dst) ||
                     (dec.rt_use && dec.rt == q.dst));

    assign bus.in_ready = !rst && !halted && !hlt_held && !hazard &&
                          (!vld_q || bus.out_ready);

    assign acc    = bus.in_valid && bus.in_ready;
    assign xfer   = vld_q && bus.out_ready;
    assign bubble = hazard && xfer;

    assign bus.out_valid  = vld_q;
    assign bus.out_pc     = pc_q;
    assign bus.out_cls    = q.cls;
    assign bus.out_alu    = q.alu;
    assign bus.out_rs     = q.rs;
    assign bus.out_rt     = q.rt;
    assign bus.out_rs_use = q.rs_use;
    assign bus.out_rt_use = q.rt_use;
    assign bus.out_dst    = q.dst;
    assign bus.out_wr     = q.wr;
    assign bus.out_imm    = q.imm;
    assign bus.out_bz     = q.bz;

    always_ff @(posedge clk1) begin
        if (rst) begin
            q         <= '0;
            pc_q      <= '0;
            vld_q     <= 1'b0;
            hlt_held  <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            stall_cnt <= '0;
            dec_cnt   <= '0;
        end else begin
            if (acc) begin
                q        <= dec;
                pc_q     <= bus.in_pc;
                vld_q    <= 1'b1;
                hlt_held <= dec.stop;
            end else if (xfer) begin
                vld_q    <= 1'b0;
            end
            if (xfer && q.stop) begin
                halted <= 1'b1;
            end
            if (xfer && q.ill) begin
                illegal <= 1'b1;
            end
            if (xfer && dec_cnt != '1) begin
                dec_cnt <= dec_cnt + 1'b1;
            end
            if (bubble && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
endmodule
